// File: rtl/main_memory_responder_if.sv
// main_memory_responder_if
//   Bundles the RD/WR/ACK handshake and the address/data buses between the
//   control unit (master) and the word-organised main memory (slave).
//   Signals:
//     Main_Memory_RD / Main_Memory_WR   request strobes from the MIR
//     Main_Memory_Address_InBUS         byte address
//     Main_Memory_data_InBUS            write data
//     Main_Memory_data_OutBUS           registered read data
//     Main_Memory_ACK                   one-cycle access-complete pulse
//     Main_Memory_Error                 one-cycle pulse with ACK on a bad access
interface main_memory_responder_if #(
  parameter int DATAWIDTH_BUS = 32
);
  logic                     Main_Memory_RD;
  logic                     Main_Memory_WR;
  logic [DATAWIDTH_BUS-1:0] Main_Memory_Address_InBUS;
  logic [DATAWIDTH_BUS-1:0] Main_Memory_data_InBUS;
  logic [DATAWIDTH_BUS-1:0] Main_Memory_data_OutBUS;
  logic                     Main_Memory_ACK;
  logic                     Main_Memory_Error;

  modport master (
    output Main_Memory_RD,
    output Main_Memory_WR,
    output Main_Memory_Address_InBUS,
    output Main_Memory_data_InBUS,
    input  Main_Memory_data_OutBUS,
    input  Main_Memory_ACK,
    input  Main_Memory_Error
  );

  modport slave (
    input  Main_Memory_RD,
    input  Main_Memory_WR,
    input  Main_Memory_Address_InBUS,
    input  Main_Memory_data_InBUS,
    output Main_Memory_data_OutBUS,
    output Main_Memory_ACK,
    output Main_Memory_Error
  );
endinterface

// File: rtl/main_memory_responder.sv
// main_memory_responder
//   Word-organised main memory answering the control unit's RD/WR/ACK
//   handshake. One request is latched in IDLE, WAIT_STATES extra cycles are
//   spent in WAIT, and the write/read is committed on the edge entering DONE.
//   DONE drives ACK (and Error when the access was misaligned or had RD and
//   WR both high) for exactly one cycle, then the FSM returns to IDLE.
//   Ports:
//     Main_Memory_CLOCK_50      system clock, rising edge
//     Main_Memory_RESET_InHigh  asynchronous reset, active-high
//     bus                       slave side of main_memory_responder_if
//   Parameters:
//     DATAWIDTH_BUS       data word and address bus width
//     DATAWIDTH_ADDR_MEM  word-index width, depth = 2**DATAWIDTH_ADDR_MEM
//     WAIT_STATES         extra cycles between capture and ACK (0..15)
//     INIT_FILE           name of the hex memory image for the image flow;
//                         an empty string means the array starts undefined
module main_memory_responder #(
  parameter int    DATAWIDTH_BUS      = 32,
  parameter int    DATAWIDTH_ADDR_MEM = 8,
  parameter int    WAIT_STATES        = 2,
  parameter string INIT_FILE          = ""
) (
  input  logic                   Main_Memory_CLOCK_50,
  input  logic                   Main_Memory_RESET_InHigh,
  main_memory_responder_if.slave bus
);

  localparam int DEPTH = 1 << DATAWIDTH_ADDR_MEM;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [3:0]                    cnt;
  logic                          req;
  logic                          capture;
  logic                          commit;
  logic                          bad_access;

  logic                          wr_p0;
  logic                          err_p0;
  logic [DATAWIDTH_ADDR_MEM-1:0] idx_p0;
  logic [DATAWIDTH_BUS-1:0]      wdata_p0;

  logic                          wr_sel;
  logic [DATAWIDTH_ADDR_MEM-1:0] idx_sel;
  logic [DATAWIDTH_BUS-1:0]      wdata_sel;

  logic [DATAWIDTH_BUS-1:0]      rdata_p1;
  logic [DATAWIDTH_BUS-1:0]      mem [DEPTH];

  // Address bits above the word index and the byte-lane bits take no part in
  // addressing; they only feed the misalignment check (bits [1:0]).
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.Main_Memory_Address_InBUS[DATAWIDTH_BUS-1:DATAWIDTH_ADDR_MEM+2];

  assign req        = bus.Main_Memory_RD | bus.Main_Memory_WR;
  assign capture    = (state == S_IDLE) && req;
  assign bad_access = (bus.Main_Memory_Address_InBUS[1:0] != 2'b00) ||
                      (bus.Main_Memory_RD && bus.Main_Memory_WR);

  // With zero wait states the capture edge is also the commit edge, so the
  // access must be taken from the live bus rather than the latched copy.
  assign wr_sel    = (state == S_IDLE) ? (bus.Main_Memory_WR & ~bus.Main_Memory_RD) : wr_p0;
  assign idx_sel   = (state == S_IDLE) ?
                     bus.Main_Memory_Address_InBUS[DATAWIDTH_ADDR_MEM+1:2] : idx_p0;
  assign wdata_sel = (state == S_IDLE) ? bus.Main_Memory_data_InBUS : wdata_p0;

  // Commit happens on the edge that enters DONE.
  assign commit = (state_next == S_DONE) && (state != S_DONE);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_next = (WAIT_STATES > 0) ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // p0: control state, wait counter, error flag and registered read data
  always_ff @(posedge Main_Memory_CLOCK_50 or posedge Main_Memory_RESET_InHigh) begin
    if (Main_Memory_RESET_InHigh) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      err_p0   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        cnt    <= WAIT_INIT;
        err_p0 <= bad_access;
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !wr_sel) begin
        rdata_p1 <= mem[idx_sel];
      end
    end
  end

  // p0: request payload; only meaningful after a capture
  always_ff @(posedge Main_Memory_CLOCK_50) begin
    if (capture) begin
      wr_p0    <= bus.Main_Memory_WR & ~bus.Main_Memory_RD;
      idx_p0   <= bus.Main_Memory_Address_InBUS[DATAWIDTH_ADDR_MEM+1:2];
      wdata_p0 <= bus.Main_Memory_data_InBUS;
    end
  end

  // p1: memory array; a reset held across the edge suppresses the write
  always_ff @(posedge Main_Memory_CLOCK_50) begin
    if (commit && wr_sel && !Main_Memory_RESET_InHigh) begin
      mem[idx_sel] <= wdata_sel;
    end
  end

  assign bus.Main_Memory_data_OutBUS = rdata_p1;
  assign bus.Main_Memory_ACK         = (state == S_DONE);
  assign bus.Main_Memory_Error       = (state == S_DONE) && err_p0;

endmodule
